// File: rtl/serial_frame_deserializer_pkg.sv
// Shared definitions for the serial frame deserializer: byte width, default
// sync byte and FSM state codes.
package serial_frame_deserializer_pkg;

   localparam int BYTE_W = 8;
   localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

   typedef enum logic {
      ST_HUNT    = 1'b0,
      ST_PAYLOAD = 1'b1
   } state_e;

endpackage

// File: rtl/serial_frame_deserializer_byte_fifo2.sv
// Two-entry shifting byte FIFO. The head register drives dout directly, so the
// last popped byte stays visible after the buffer empties.
module serial_frame_deserializer_byte_fifo2
   import serial_frame_deserializer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [BYTE_W-1:0] din,
   input  logic              pop,
   output logic [BYTE_W-1:0] dout,
   output logic              valid,
   output logic              full
);

   logic [BYTE_W-1:0] head_q, head_d;
   logic [BYTE_W-1:0] tail_q, tail_d;
   logic [1:0]        count_q, count_d;
   logic              pop_eff;

   assign pop_eff = pop & (count_q != 2'd0);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case (count_q)
         2'd0: begin
            // Pop on empty is meaningless; a push lands next cycle, no bypass.
            if (push) begin
               head_d  = din;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            case ({push, pop_eff})
               2'b10: begin
                  tail_d  = din;
                  count_d = 2'd2;
               end
               2'b01:   count_d = 2'd0;
               2'b11:   head_d  = din;
               default: ;
            endcase
         end
         2'd2: begin
            if (pop_eff) begin
               head_d = tail_q;
               if (push) tail_d  = din;
               else      count_d = 2'd1;
            end
         end
         default: count_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign dout  = head_q;
   assign valid = (count_q != 2'd0);
   assign full  = (count_q == 2'd2);

endmodule

// File: rtl/serial_frame_deserializer.sv
// MSB-first serial-to-byte deserializer: hunts a sync byte on a sliding window,
// then assembles FRAME_BYTES payload bytes into a 2-entry valid/ready buffer.
module serial_frame_deserializer
   import serial_frame_deserializer_pkg::*;
#(
   parameter logic [BYTE_W-1:0] SYNC        = SYNC_BYTE,
   parameter int                FRAME_BYTES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              si,
   output logic [BYTE_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              in_sync,
   output logic              frame_done,
   output logic              overflow
);

   // Handshake: a byte moves on a clk edge where out_valid & out_ready are both
   // high; out_valid never drops without a pop and out_data is stable while valid.

   localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

   state_e            state_q, state_d;
   logic [BYTE_W-1:0] window_q, window_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        byte_cnt_q, byte_cnt_d;
   logic              frame_done_q, frame_done_d;
   logic              overflow_q, overflow_d;

   logic [BYTE_W-1:0] shifted;
   logic              sync_hit, byte_last, frame_last;
   logic              push_req, push_ok, pop, fifo_full, fifo_valid;

   assign shifted    = {window_q[BYTE_W-2:0], si};
   assign sync_hit   = (shifted == SYNC);
   assign byte_last  = (bit_cnt_q == 3'd7);
   assign frame_last = (byte_cnt_q == LAST_BYTE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_HUNT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HUNT:    if (sync_hit) state_d = ST_PAYLOAD;
         ST_PAYLOAD: if (byte_last && frame_last) state_d = ST_HUNT;
         default:    state_d = ST_HUNT;
      endcase
   end

   always_comb begin
      window_d     = shifted;
      bit_cnt_d    = 3'd0;
      byte_cnt_d   = byte_cnt_q;
      push_req     = 1'b0;
      frame_done_d = 1'b0;
      case (state_q)
         ST_HUNT: byte_cnt_d = 8'd0;
         ST_PAYLOAD: begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_last) begin
               push_req   = 1'b1;
               byte_cnt_d = byte_cnt_q + 8'd1;
               // Clearing the window keeps the payload tail from faking a sync.
               if (frame_last) begin
                  frame_done_d = 1'b1;
                  window_d     = '0;
                  byte_cnt_d   = 8'd0;
               end
            end
         end
         default: byte_cnt_d = 8'd0;
      endcase
   end

   assign pop        = fifo_valid & out_ready;
   assign push_ok    = push_req & (~fifo_full | pop);
   assign overflow_d = overflow_q | (push_req & ~push_ok);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         window_q     <= '0;
         bit_cnt_q    <= 3'd0;
         byte_cnt_q   <= 8'd0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         window_q     <= window_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
      end
   end

   serial_frame_deserializer_byte_fifo2 u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_ok),
      .din   (shifted),
      .pop   (pop),
      .dout  (out_data),
      .valid (fifo_valid),
      .full  (fifo_full)
   );

   assign out_valid  = fifo_valid;
   assign in_sync    = (state_q == ST_PAYLOAD);
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer: a 2-byte-frame and a 4-byte-frame
// instance share one serial stream; popped bytes are scored against exp_q.
module tb_serial_frame_deserializer;

   logic       clk;
   logic       reset;
   logic       si;
   logic       out_ready;

   logic [7:0] out_data2, out_data4;
   logic       out_valid2, out_valid4;
   logic       in_sync2, in_sync4;
   logic       frame_done2, frame_done4;
   logic       overflow2, overflow4;

   int         n_vec = 0;
   int         n_bad = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   serial_frame_deserializer #(.FRAME_BYTES(2)) dut2 (
      .clk        (clk),
      .reset      (reset),
      .si         (si),
      .out_data   (out_data2),
      .out_valid  (out_valid2),
      .out_ready  (out_ready),
      .in_sync    (in_sync2),
      .frame_done (frame_done2),
      .overflow   (overflow2)
   );

   serial_frame_deserializer #(.FRAME_BYTES(4)) dut4 (
      .clk        (clk),
      .reset      (reset),
      .si         (si),
      .out_data   (out_data4),
      .out_valid  (out_valid4),
      .out_ready  (out_ready),
      .in_sync    (in_sync4),
      .frame_done (frame_done4),
      .overflow   (overflow4)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // pop monitor on the 4-byte instance
   always @(posedge clk) begin
      if (!reset && out_valid4 && out_ready) got_q.push_back(out_data4);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks: each bit is driven 1 time unit after a posedge and sampled
   // on the following posedge; outputs are checked 1 unit after that edge
   task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         si = b[i];
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(b, 7, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_bits(8'h00, 0, 0);
   endtask

   task automatic reset_dut();
      #3 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_stream(input string tag);
      check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      reset     = 1'b1;
      si        = 1'b0;
      out_ready = 1'b0;
      #1;
      check("por_data",  32'(out_data4),   32'h00);
      check("por_valid", 32'(out_valid4),  32'h0);
      check("por_sync",  32'(in_sync4),    32'h0);
      check("por_done",  32'(frame_done4), 32'h0);
      check("por_ovf",   32'(overflow4),   32'h0);
      @(posedge clk);
      #1 reset = 1'b0;

      // 2-byte frame A5 3C C3 with the consumer always ready
      out_ready = 1'b1;
      send_byte(8'hA5);
      check("t2_sync_on", 32'(in_sync2), 32'h1);
      send_byte(8'h3C);
      check("t2_b0_valid", 32'(out_valid2),  32'h1);
      check("t2_b0_data",  32'(out_data2),   32'h3C);
      check("t2_b0_done",  32'(frame_done2), 32'h0);
      send_bits(8'hC3, 7, 7);
      check("t2_popped_valid", 32'(out_valid2), 32'h0);
      check("t2_held_data",    32'(out_data2),  32'h3C);
      send_bits(8'hC3, 6, 0);
      check("t2_b1_valid", 32'(out_valid2),  32'h1);
      check("t2_b1_data",  32'(out_data2),   32'hC3);
      check("t2_b1_done",  32'(frame_done2), 32'h1);
      check("t2_sync_off", 32'(in_sync2),    32'h0);
      idle(1);
      check("t2_done_pulse", 32'(frame_done2), 32'h0);
      check("t2_drained",    32'(out_valid2),  32'h0);

      // unaligned hunt: A5 sits one bit into 52 D2 80; payload is bit-shifted
      reset_dut();
      out_ready = 1'b1;
      send_byte(8'h52);
      check("t3_no_sync", 32'(in_sync4), 32'h0);
      send_bits(8'hD2, 7, 7);
      check("t3_sync", 32'(in_sync4), 32'h1);
      send_bits(8'hD2, 6, 0);
      send_byte(8'h80);
      send_byte(8'h11);
      send_byte(8'h22);
      send_bits(8'h33, 7, 7);
      check("t3_done",     32'(frame_done4), 32'h1);
      check("t3_sync_off", 32'(in_sync4),    32'h0);
      send_bits(8'h33, 6, 0);
      idle(2);
      exp_q = '{8'hA5, 8'h00, 8'h22, 8'h44};
      check_stream("t3");
      check("t3_no_ovf", 32'(overflow4), 32'h0);

      // consumer stalled: third and fourth bytes are dropped
      reset_dut();
      out_ready = 1'b0;
      send_byte(8'hA5);
      send_byte(8'h11);
      send_byte(8'h22);
      check("t4_full_no_ovf", 32'(overflow4), 32'h0);
      send_byte(8'h33);
      check("t4_ovf_set", 32'(overflow4), 32'h1);
      send_byte(8'h44);
      check("t4_head",  32'(out_data4),  32'h11);
      check("t4_valid", 32'(out_valid4), 32'h1);
      check("t4_hunt",  32'(in_sync4),   32'h0);
      out_ready = 1'b1;
      idle(4);
      exp_q = '{8'h11, 8'h22};
      check_stream("t4");
      check("t4_ovf_sticky", 32'(overflow4),  32'h1);
      check("t4_empty",      32'(out_valid4), 32'h0);
      check("t4_hold_data",  32'(out_data4),  32'h22);

      // pop on the same edge as a push into a full buffer
      reset_dut();
      out_ready = 1'b0;
      send_byte(8'hA5);
      send_byte(8'h11);
      send_byte(8'h22);
      send_bits(8'h33, 7, 1);
      out_ready = 1'b1;
      send_bits(8'h33, 0, 0);
      check("t5_no_ovf", 32'(overflow4),  32'h0);
      check("t5_head",   32'(out_data4),  32'h22);
      check("t5_valid",  32'(out_valid4), 32'h1);
      send_byte(8'h44);
      idle(4);
      exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      check_stream("t5");
      check("t5_no_ovf_end", 32'(overflow4), 32'h0);

      // asynchronous reset mid-frame with a full buffer and overflow set
      reset_dut();
      out_ready = 1'b0;
      send_byte(8'hA5);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_bits(8'h44, 7, 5);
      check("t6_pre_sync", 32'(in_sync4),  32'h1);
      check("t6_pre_ovf",  32'(overflow4), 32'h1);
      #3 reset = 1'b1;
      #1;
      check("t6_rst_data",  32'(out_data4),   32'h00);
      check("t6_rst_valid", 32'(out_valid4),  32'h0);
      check("t6_rst_sync",  32'(in_sync4),    32'h0);
      check("t6_rst_done",  32'(frame_done4), 32'h0);
      check("t6_rst_ovf",   32'(overflow4),   32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      got_q.delete();
      out_ready = 1'b1;
      send_byte(8'hA5);
      send_byte(8'hDE);
      send_byte(8'hAD);
      send_byte(8'hBE);
      send_byte(8'hEF);
      check("t6_done", 32'(frame_done4), 32'h1);
      idle(2);
      exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      check_stream("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
